jog_ctrl: RTL and testbench

- Upstream stage of the PWM output block: converts the four raw push-buttons into two 6-bit duty-cycle words, DC_X and DC_Y.
- Each button is synchronised and debounced, then feeds a per-axis step/auto-repeat FSM with saturating arithmetic.
- Output words feed both the PWM comparator and the storage RAM directly.

---
 rtl/jog_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 39 +++
 rtl/jog_ctrl.sv | 169 ++++++++++++++++
 tb/tb_jog_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jog_pkg.sv
// Shared types and helpers for the jog button front-end: duty width, axis FSM
// states, axis command encoding and the repeat-timer width helper.
package jog_pkg;

  localparam int DC_W = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    WAIT   = ST_WAIT,
    REPEAT = ST_REPEAT
  } axis_state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_INC  = 2'b01,
    CMD_DEC  = 2'b10
  } axis_cmd_t;

  // One timer serves both the first-repeat delay and the repeat period.
  function automatic int timer_w(input int delay_cycles, input int rate_cycles);
    int m;
    m = (delay_cycles > rate_cycles) ? delay_cycles : rate_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a debounce counter: the output level flips
// only after DEB_CYCLES consecutive synced samples disagree with it.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/jog_ctrl.sv
// Converts four raw push-buttons into saturating X/Y duty words with a
// step-then-auto-repeat behaviour per axis.
module jog_ctrl
  import jog_pkg::*;
#(
  parameter int DEB_CYCLES   = 250000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int STEP         = 1,
  parameter int DC_MIN       = 0,
  parameter int DC_MAX       = 63,
  parameter int DC_INIT      = 32
) (
  input  logic            sysclk,
  input  logic            Reset_Sw,
  input  logic            Bt_Up,
  input  logic            Bt_Down,
  input  logic            Bt_Left,
  input  logic            Bt_Right,
  output logic [DC_W-1:0] DC_X,
  output logic [DC_W-1:0] DC_Y,
  output logic            Step_X,
  output logic            Step_Y,
  output axis_state_t     o_dbg_state_x,
  output axis_state_t     o_dbg_state_y
);

  localparam int TMR_W = timer_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
  localparam logic [DC_W:0]    STEP7      = (DC_W + 1)'(STEP);
  localparam logic [DC_W:0]    MAX7       = (DC_W + 1)'(DC_MAX);
  localparam logic [DC_W:0]    DEC_FLOOR7 = (DC_W + 1)'(DC_MIN + STEP);
  localparam logic [DC_W-1:0]  STEP6      = DC_W'(STEP);
  localparam logic [DC_W-1:0]  MIN6       = DC_W'(DC_MIN);
  localparam logic [DC_W-1:0]  MAX6       = DC_W'(DC_MAX);
  localparam logic [DC_W-1:0]  INIT6      = DC_W'(DC_INIT);

  logic [3:0]        w_raw;
  logic [3:0]        w_deb;
  logic [1:0]        w_inc;
  logic [1:0]        w_dec;
  logic [2*DC_W-1:0] w_dc;
  logic [1:0]        w_step;
  logic [3:0]        w_st;

  assign w_raw = {Bt_Right, Bt_Left, Bt_Down, Bt_Up};

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk  (sysclk),
      .i_rst  (Reset_Sw),
      .i_btn  (w_raw[b]),
      .o_level(w_deb[b])
    );
  end

  // Axis 0 is X (Right/Left), axis 1 is Y (Up/Down).
  assign w_inc = {w_deb[0], w_deb[3]};
  assign w_dec = {w_deb[1], w_deb[2]};

  // Step_X/Step_Y qualify DC_X/DC_Y: high for exactly the cycle a new value
  // appears on the duty word; there is no back-pressure from downstream.
  for (genvar a = 0; a < 2; a++) begin : g_axis
    axis_cmd_t        w_cmd;
    axis_cmd_t        r_cmd;
    axis_state_t      r_state;
    axis_state_t      w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [DC_W-1:0]  r_dc;
    logic [DC_W-1:0]  w_dc_inc;
    logic [DC_W-1:0]  w_dc_dec;
    logic [DC_W-1:0]  w_dc_nxt;
    logic [DC_W:0]    w_sum;
    logic             r_step;
    logic             w_apply;

    always_comb begin
      w_cmd = CMD_NONE;
      if (w_inc[a] && !w_dec[a]) begin
        w_cmd = CMD_INC;
      end else if (w_dec[a] && !w_inc[a]) begin
        w_cmd = CMD_DEC;
      end
    end

    // Saturating arithmetic is done one bit wider so the add can never wrap.
    always_comb begin
      w_sum    = {1'b0, r_dc} + STEP7;
      w_dc_inc = (w_sum > MAX7) ? MAX6 : w_sum[DC_W-1:0];
      w_dc_dec = ({1'b0, r_dc} >= DEC_FLOOR7) ? (r_dc - STEP6) : MIN6;
      w_dc_nxt = (w_cmd == CMD_INC) ? w_dc_inc : w_dc_dec;
    end

    always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_apply     = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd != CMD_NONE) begin
            w_apply     = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (w_cmd != r_cmd) begin
            w_timer_nxt = '0;
            w_state_nxt = IDLE;
          end else if (r_timer == DELAY_LAST) begin
            w_apply     = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = REPEAT;
          end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
          end
        end
        REPEAT: begin
          if (w_cmd != r_cmd) begin
            w_timer_nxt = '0;
            w_state_nxt = IDLE;
          end else if (r_timer == RATE_LAST) begin
            w_apply     = 1'b1;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
          end
        end
        default: begin
          w_timer_nxt = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end

    // r_cmd is the previous cycle's command; it only matters while engaged.
    always_ff @(posedge sysclk) begin
      if (Reset_Sw) begin
        r_state <= IDLE;
        r_cmd   <= CMD_NONE;
        r_timer <= '0;
        r_dc    <= INIT6;
        r_step  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cmd   <= w_cmd;
        r_timer <= w_timer_nxt;
        r_step  <= w_apply && (w_dc_nxt != r_dc);
        if (w_apply) begin
          r_dc <= w_dc_nxt;
        end
      end
    end

    assign w_dc[a*DC_W +: DC_W] = r_dc;
    assign w_step[a]            = r_step;
    assign w_st[a*2 +: 2]       = r_state;
  end

  assign DC_X          = w_dc[DC_W-1:0];
  assign DC_Y          = w_dc[2*DC_W-1:DC_W];
  assign Step_X        = w_step[0];
  assign Step_Y        = w_step[1];
  assign o_dbg_state_x = axis_state_t'(w_st[1:0]);
  assign o_dbg_state_y = axis_state_t'(w_st[3:2]);

endmodule

// File: tb/tb_jog_ctrl.sv
// Self-checking bench for jog_ctrl: directed scenarios plus random button
// traffic, scored against a hold-time based reference model.
module tb_jog_ctrl;
  import jog_pkg::*;

  localparam int DEB    = 4;
  localparam int RD     = 20;
  localparam int RR     = 5;
  localparam int STEP   = 1;
  localparam int DCMIN  = 0;
  localparam int DCMAX  = 63;
  localparam int DCINIT = 32;
  localparam int W      = 22;

  localparam logic [3:0] UP    = 4'b0001;
  localparam logic [3:0] DOWN  = 4'b0010;
  localparam logic [3:0] LEFT  = 4'b0100;
  localparam logic [3:0] RIGHT = 4'b1000;

  // ---------------- clock / reset / DUT ----------------
  logic        sysclk = 1'b0;
  logic        Reset_Sw;
  logic        Bt_Up, Bt_Down, Bt_Left, Bt_Right;
  logic [5:0]  DC_X, DC_Y;
  logic        Step_X, Step_Y;
  axis_state_t dbg_x, dbg_y;

  always #5 sysclk = ~sysclk;

  jog_ctrl #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .STEP(STEP),
    .DC_MIN(DCMIN), .DC_MAX(DCMAX), .DC_INIT(DCINIT)
  ) dut (
    .sysclk(sysclk), .Reset_Sw(Reset_Sw),
    .Bt_Up(Bt_Up), .Bt_Down(Bt_Down), .Bt_Left(Bt_Left), .Bt_Right(Bt_Right),
    .DC_X(DC_X), .DC_Y(DC_Y), .Step_X(Step_X), .Step_Y(Step_Y),
    .o_dbg_state_x(dbg_x), .o_dbg_state_y(dbg_y)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [W-1:0] exp_x_q[$];
  logic [W-1:0] exp_y_q[$];
  int step_cnt[2];
  int last_step_cyc[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce: a level flips once the last DEB synced samples all disagree.
  // Axis: once engaged with a command, steps fall at hold ages 0, RD, RD+RR, ...
  logic [15:0] sh[4];
  logic [3:0]  mdeb;
  int          eng[2];
  int          age[2];
  int          mdc[2];

  function automatic int sat_step(input int dc, input int dir);
    if (dir > 0) return (dc + STEP > DCMAX) ? DCMAX : dc + STEP;
    return (dc >= DCMIN + STEP) ? dc - STEP : DCMIN;
  endfunction

  task automatic model_edge();
    logic [3:0] raw;
    int         c;
    int         nd;
    bit         fire;
    bit         all_diff;
    bit         inc;
    bit         dec;
    raw = {Bt_Right, Bt_Left, Bt_Down, Bt_Up};
    cyc++;
    if (Reset_Sw) begin
      for (int b = 0; b < 4; b++) sh[b] = '0;
      mdeb = '0;
      for (int a = 0; a < 2; a++) begin
        eng[a] = 0; age[a] = 0; mdc[a] = DCINIT;
      end
      return;
    end
    for (int a = 0; a < 2; a++) begin
      inc  = (a == 0) ? mdeb[3] : mdeb[0];
      dec  = (a == 0) ? mdeb[2] : mdeb[1];
      c    = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
      fire = 1'b0;
      if (eng[a] == 0) begin
        if (c != 0) begin
          eng[a] = c; age[a] = 0; fire = 1'b1;
        end
      end else if (c != eng[a]) begin
        eng[a] = 0;
      end else begin
        age[a]++;
        if (age[a] == RD || (age[a] > RD && (age[a] - RD) % RR == 0)) fire = 1'b1;
      end
      if (fire) begin
        nd = sat_step(mdc[a], c);
        if (nd != mdc[a]) begin
          if (a == 0) exp_x_q.push_back({cyc[15:0], 6'(nd)});
          else        exp_y_q.push_back({cyc[15:0], 6'(nd)});
        end
        mdc[a] = nd;
      end
    end
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DEB; k++) if (sh[b][k] == mdeb[b]) all_diff = 1'b0;
      if (all_diff) mdeb[b] = ~mdeb[b];
      sh[b] = {sh[b][14:0], raw[b]};
    end
  endtask

  initial begin
    forever begin
      @(posedge sysclk);
      model_edge();
    end
  end

  // ---------------- monitor ----------------
  task automatic mon_axis(input int a, input logic stp, input logic [5:0] dc);
    logic [W-1:0] e;
    string        nm;
    nm = (a == 0) ? "step_x" : "step_y";
    if (a == 0) begin
      while (exp_x_q.size() > 0 && exp_x_q[0][W-1:6] < cyc[15:0]) begin
        e = exp_x_q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL %s_missing: no pulse, required DC=%0d at cycle %0d", nm, e[5:0], e[W-1:6]);
      end
    end else begin
      while (exp_y_q.size() > 0 && exp_y_q[0][W-1:6] < cyc[15:0]) begin
        e = exp_y_q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL %s_missing: no pulse, required DC=%0d at cycle %0d", nm, e[5:0], e[W-1:6]);
      end
    end
    if (stp === 1'b1) begin
      step_cnt[a]++;
      last_step_cyc[a] = cyc;
      if ((a == 0 && exp_x_q.size() == 0) || (a == 1 && exp_y_q.size() == 0)) begin
        n_tests++; n_fail++;
        $display("FAIL %s_unexpected: got pulse with DC=%0d at cycle %0d, required none", nm, dc, cyc);
      end else begin
        e = (a == 0) ? exp_x_q.pop_front() : exp_y_q.pop_front();
        check({nm, "_cycle"}, 32'(cyc[15:0]), 32'(e[W-1:6]));
        check({nm, "_value"}, 32'(dc), 32'(e[5:0]));
      end
    end
  endtask

  initial begin
    step_cnt[0] = 0; step_cnt[1] = 0;
    last_step_cyc[0] = -1; last_step_cyc[1] = -1;
    forever begin
      @(negedge sysclk);
      mon_axis(0, Step_X, DC_X);
      mon_axis(1, Step_Y, DC_Y);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic drive(input logic [3:0] mask);
    {Bt_Right, Bt_Left, Bt_Down, Bt_Up} = mask;
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    drive(mask);
    tick(hold);
    drive(4'b0000);
    tick(gap);
  endtask

  // ---------------- stimulus ----------------
  int c0, s0, s1;

  initial begin
    Reset_Sw = 1'b1;
    drive(4'b0000);
    tick(3);
    check("reset_dc_x", 32'(DC_X), 32);
    check("reset_dc_y", 32'(DC_Y), 32);
    check("reset_step_x", 32'(Step_X), 0);
    check("reset_step_y", 32'(Step_Y), 0);
    check("reset_state_x", 32'(dbg_x), 32'(IDLE));
    check("reset_state_y", 32'(dbg_y), 32'(IDLE));
    Reset_Sw = 1'b0;
    tick(2);

    // single short press: one step, seven cycles after the press
    c0 = cyc; s0 = step_cnt[0]; s1 = step_cnt[1];
    press(RIGHT, 10, 12);
    check("t1_dc_x", 32'(DC_X), 33);
    check("t1_dc_y", 32'(DC_Y), 32);
    check("t1_pulses_x", 32'(step_cnt[0] - s0), 1);
    check("t1_latency", 32'(last_step_cyc[0]), 32'(c0 + 7));
    check("t1_pulses_y", 32'(step_cnt[1] - s1), 0);

    // glitch shorter than the debounce window
    s1 = step_cnt[1];
    press(UP, 3, 12);
    check("t2_dc_y", 32'(DC_Y), 32);
    check("t2_pulses_y", 32'(step_cnt[1] - s1), 0);

    // long hold: first step, delayed repeat, then periodic repeats
    press(UP, 66, 12);
    check("t3_dc_y", 32'(DC_Y), 43);
    check("t3_dc_y_model", 32'(DC_Y), 32'(mdc[1]));

    // upper saturation, then lower saturation
    for (int i = 0; i < 40 && mdc[0] != 62; i++) press(RIGHT, 8, 8);
    check("t4_preset_x", 32'(DC_X), 62);
    s0 = step_cnt[0];
    press(RIGHT, 40, 12);
    check("t4_sat_hi_x", 32'(DC_X), 63);
    check("t4_sat_hi_pulses", 32'(step_cnt[0] - s0), 1);
    press(LEFT, 400, 12);
    check("t4_sat_lo_x", 32'(DC_X), 0);
    s0 = step_cnt[0];
    press(LEFT, 40, 12);
    check("t4_sat_lo_x2", 32'(DC_X), 0);
    check("t4_sat_lo_pulses", 32'(step_cnt[0] - s0), 0);

    // both Y buttons together cancel; releasing Down starts an Up step
    drive(UP | DOWN);
    tick(40);
    check("t5_both_dc_y", 32'(DC_Y), 43);
    check("t5_both_state_y", 32'(dbg_y), 32'(IDLE));
    drive(UP);
    c0 = cyc;
    tick(15);
    drive(4'b0000);
    tick(12);
    check("t5_dc_y", 32'(DC_Y), 44);
    check("t5_latency", 32'(last_step_cyc[1]), 32'(c0 + 7));

    // reset while Left is held in auto-repeat
    drive(LEFT);
    tick(40);
    check("t6_state_x", 32'(dbg_x), 32'(REPEAT));
    Reset_Sw = 1'b1;
    tick(1);
    check("t6_reset_dc_x", 32'(DC_X), 32);
    check("t6_reset_dc_y", 32'(DC_Y), 32);
    check("t6_reset_state_x", 32'(dbg_x), 32'(IDLE));
    Reset_Sw = 1'b0;
    c0 = cyc;
    tick(10);
    check("t6_latency", 32'(last_step_cyc[0]), 32'(c0 + 7));
    check("t6_dc_x", 32'(DC_X), 31);
    drive(4'b0000);
    tick(12);

    // random traffic scored by the reference model
    for (int i = 0; i < 60; i++) begin
      drive(4'($urandom_range(0, 15)));
      tick($urandom_range(1, 45));
      if ($urandom_range(0, 11) == 0) begin
        Reset_Sw = 1'b1;
        tick(1);
        Reset_Sw = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        drive(4'b0000);
        tick($urandom_range(1, 12));
      end
    end
    drive(4'b0000);
    tick(40);
    check("rand_dc_x", 32'(DC_X), 32'(mdc[0]));
    check("rand_dc_y", 32'(DC_Y), 32'(mdc[1]));
    check("rand_pending_x", 32'(exp_x_q.size()), 0);
    check("rand_pending_y", 32'(exp_y_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
